// File: rtl/burst_mem_pkg.sv
// ============================================================================
//  Module   : burst_mem_pkg
//  Purpose  : Shared types and constants for the burst memory responder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package burst_mem_pkg;

  localparam int BEATS    = 4;
  localparam int BEAT_W   = 64;
  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;

  typedef logic [$clog2(BEATS)-1:0] beat_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/burst_mem_array.sv
// ============================================================================
//  Module   : burst_mem_array
//  Purpose  : Unreset cacheline storage, one registered 64-bit read port and
//             one beat-granular write port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module burst_mem_array
  import burst_mem_pkg::*;
#(
  parameter int DEPTH_LINES = 256,
  parameter int IDX_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  input  beat_t             rd_beat_i,
  output logic [BEAT_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  beat_t             wr_beat_i,
  input  logic [BEAT_W-1:0] wr_data_i
);

  // Each line is stored as BEATS consecutive words addressed by {index, beat}.
  logic [BEAT_W-1:0] mem_q [DEPTH_LINES*BEATS];
  logic [BEAT_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[{wr_idx_i, wr_beat_i}] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[{rd_idx_i, rd_beat_i}];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/burst_mem_responder.sv
// ============================================================================
//  Module   : burst_mem_responder
//  Purpose  : 4-beat 64-bit pmem burst target with programmable latency.
//             Optional protocol checker: define BURST_MEM_PROTO_CHK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module burst_mem_responder
  import burst_mem_pkg::*;
#(
  parameter int DEPTH_LINES = 256,
  parameter int LATENCY     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [31:0]       pmem_address,
  input  logic [BEAT_W-1:0] pmem_wdata,
  output logic [BEAT_W-1:0] pmem_rdata,
  output logic              pmem_resp,
  output logic              proto_err
);

  localparam int         c_IDX_W  = $clog2(DEPTH_LINES);
  localparam logic [7:0] c_LAT_M1 = (LATENCY > 0) ? 8'(LATENCY - 1) : 8'd0;

  state_e               state_q, state_d;
  logic                 is_rd_q, is_rd_d;
  logic [c_IDX_W-1:0]   idx_q,   idx_d;
  beat_t                beat_q,  beat_d;
  logic [7:0]           cnt_q,   cnt_d;
  logic                 resp_q;
  logic                 w_req;
  logic                 w_rd_en;
  logic                 w_wr_en;

  assign w_req = pmem_read | pmem_write;

  always_comb begin
    state_d = state_q;
    is_rd_d = is_rd_q;
    idx_d   = idx_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_req) begin
          is_rd_d = pmem_read;
          idx_d   = pmem_address[c_IDX_W+OFFSET_W-1:OFFSET_W];
          beat_d  = '0;
          if (LATENCY > 0) begin
            state_d = ST_WAIT;
            cnt_d   = c_LAT_M1;
          end else begin
            state_d = ST_BURST;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_BURST;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_BURST: begin
        if (beat_q == beat_t'(BEATS - 1)) begin
          state_d = ST_DONE;
        end else begin
          beat_d = beat_q + beat_t'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The array read is registered, so it is launched from next-state values
  // to land in the same cycle that resp goes high for that beat.
  assign w_rd_en = (state_d == ST_BURST) && is_rd_d;
  assign w_wr_en = (state_q == ST_BURST) && !is_rd_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      is_rd_q <= 1'b0;
      idx_q   <= '0;
      beat_q  <= '0;
      cnt_q   <= 8'd0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      is_rd_q <= is_rd_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      resp_q  <= (state_d == ST_BURST);
    end
  end

  assign pmem_resp = resp_q;

  burst_mem_array #(
    .DEPTH_LINES (DEPTH_LINES),
    .IDX_W       (c_IDX_W)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .rd_en_i   (w_rd_en),
    .rd_idx_i  (idx_d),
    .rd_beat_i (beat_d),
    .rd_data_o (pmem_rdata),
    .wr_en_i   (w_wr_en),
    .wr_idx_i  (idx_q),
    .wr_beat_i (beat_q),
    .wr_data_i (pmem_wdata)
  );

`ifdef BURST_MEM_PROTO_CHK_EN
  logic [31-OFFSET_W:0] tag_q;
  logic                 err_q;
  logic                 w_err_set;
  logic                 w_unused_addr;

  always_comb begin
    w_err_set = 1'b0;
    case (state_q)
      ST_IDLE:           w_err_set = pmem_read & pmem_write;
      ST_WAIT, ST_BURST: w_err_set = (is_rd_q ? !pmem_read : !pmem_write) ||
                                     (pmem_address[31:OFFSET_W] != tag_q);
      default:           w_err_set = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | w_err_set;
      if ((state_q == ST_IDLE) && w_req) begin
        tag_q <= pmem_address[31:OFFSET_W];
      end
    end
  end

  assign proto_err     = err_q;
  assign w_unused_addr = ^pmem_address[OFFSET_W-1:0];
`else
  logic w_unused_addr;

  assign proto_err     = 1'b0;
  assign w_unused_addr = ^{pmem_address[31:c_IDX_W+OFFSET_W],
                           pmem_address[OFFSET_W-1:0]};
`endif

endmodule

`default_nettype wire
